// File: rtl/min_key_arb_pkg.sv
// Shared definitions for the minimum-key arbiter.
//   NUM_REQ / IDX_W : requester count and index width
//   arb_state_t     : arbiter FSM states
//   onehot4()       : binary index -> one-hot grant vector
package min_key_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/min_key_arbiter_select.sv
// Combinational minimum-key search over the valid entries.
//   keys      : packed keys, entry i in keys[i]
//   valid     : per-entry valid mask; invalid entries never win
//   idx       : index of the smallest valid key, lowest index on ties
//   any_valid : at least one entry is valid
module min_key_select
    import min_key_arb_pkg::*;
#(
    parameter int KEY_W = 32
) (
    input  logic [NUM_REQ-1:0][KEY_W-1:0] keys,
    input  logic [NUM_REQ-1:0]            valid,
    output logic [IDX_W-1:0]              idx,
    output logic                          any_valid
);

    logic [KEY_W-1:0] best;
    logic             found;

    // Upward scan; strict less-than means an equal key never displaces
    // an earlier (lower-index) candidate.
    always_comb begin
        idx   = '0;
        best  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (valid[i] && (!found || keys[i] < best)) begin
                found = 1'b1;
                best  = keys[i];
                idx   = IDX_W'(i);
            end
        end
    end

    assign any_valid = found;

endmodule

// File: rtl/min_key_arbiter.sv
// Minimum-key arbiter: grants one of four requesters the shared resource,
// smallest key wins, lowest index on ties. Grant is held until done, the
// winner drops its request, or HOLD_MAX cycles elapse (timeout pulse).
// Optional starvation aging: define MIN_KEY_ARB_AGING_EN.
//   clk, rst_n        : clock, async active-low reset
//   req[3:0]          : level requests
//   key0..key3        : unsigned keys, sampled only when arbitrating
//   done              : holder finished (used only while granting)
//   gnt, gnt_vld      : registered one-hot grant and its valid
//   gnt_idx           : index of current / last winner
//   timeout           : one-cycle pulse on forced release
module min_key_arbiter
    import min_key_arb_pkg::*;
#(
    parameter int KEY_W    = 32,
    parameter int HOLD_MAX = 64,
    parameter int AGE_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [KEY_W-1:0]     key0,
    input  logic [KEY_W-1:0]     key1,
    input  logic [KEY_W-1:0]     key2,
    input  logic [KEY_W-1:0]     key3,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   gnt,
    output logic                 gnt_vld,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 timeout
);

    localparam int HC_W = $clog2(HOLD_MAX + 1);

    if (HOLD_MAX < 1 || AGE_W < 1) begin : g_bad_param
        $error("min_key_arbiter: HOLD_MAX and AGE_W must be >= 1");
    end

    arb_state_t                   state, state_nxt;
    logic [NUM_REQ-1:0]           gnt_nxt;
    logic [IDX_W-1:0]             idx_nxt;
    logic                         timeout_nxt;
    logic [HC_W-1:0]              hcnt, hcnt_nxt;
    logic [NUM_REQ-1:0][KEY_W-1:0] raw_key, eff_key;
    logic [IDX_W-1:0]             win_idx;
    logic                         any_req;

    assign raw_key = {key3, key2, key1, key0};

`ifdef MIN_KEY_ARB_AGING_EN
    logic [NUM_REQ-1:0][AGE_W-1:0] age;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] || gnt[i])
                    age[i] <= '0;
                else if (age[i] != {AGE_W{1'b1}})
                    age[i] <= age[i] + AGE_W'(1);
            end
        end
    end

    // key - age, clamped at zero
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            eff_key[i] = (raw_key[i] > KEY_W'(age[i])) ? raw_key[i] - KEY_W'(age[i]) : '0;
        end
    end
`else
    assign eff_key = raw_key;
`endif

    min_key_select #(.KEY_W(KEY_W)) u_select (
        .keys      (eff_key),
        .valid     (req),
        .idx       (win_idx),
        .any_valid (any_req)
    );

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        idx_nxt     = gnt_idx;
        hcnt_nxt    = hcnt;
        timeout_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = GRANT;
                    gnt_nxt   = onehot4(win_idx);
                    idx_nxt   = win_idx;
                    hcnt_nxt  = '0;
                end
            end
            GRANT: begin
                // done outranks abort, which outranks timeout
                if (done || !req[gnt_idx]) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                end else if (hcnt == HC_W'(HOLD_MAX - 1)) begin
                    state_nxt   = IDLE;
                    gnt_nxt     = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    hcnt_nxt = hcnt + HC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            hcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            gnt_idx <= idx_nxt;
            hcnt    <= hcnt_nxt;
            timeout <= timeout_nxt;
        end
    end

    assign gnt_vld = |gnt;

endmodule

// File: tb/tb_min_key_arbiter.sv
module tb_min_key_arbiter;

    localparam int KEY_W    = 32;
    localparam int HOLD_MAX = 4;
    localparam int AGE_W    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0]       req;
    logic [KEY_W-1:0] key0, key1, key2, key3;
    logic             done;
    logic [3:0]       gnt;
    logic             gnt_vld;
    logic [1:0]       gnt_idx;
    logic             timeout;

    always #5 clk = ~clk;

    min_key_arbiter #(.KEY_W(KEY_W), .HOLD_MAX(HOLD_MAX), .AGE_W(AGE_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .key0(key0), .key1(key1), .key2(key2), .key3(key3),
        .done(done), .gnt(gnt), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx), .timeout(timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who holds the resource, for how long, and ages.
    bit         m_busy;
    int         m_idx;
    int         m_last;
    int         m_held;
    bit         m_to;
    int         m_age [4];

    function automatic void model_reset();
        m_busy = 0; m_idx = 0; m_last = 0; m_held = 0; m_to = 0;
        foreach (m_age[i]) m_age[i] = 0;
    endfunction

    function automatic longint eff(input longint k, input int a);
`ifdef MIN_KEY_ARB_AGING_EN
        return (k > a) ? k - a : 0;
`else
        return k + 0 * a;
`endif
    endfunction

    function automatic void model_step(input logic [3:0] r, input longint k[4], input bit d);
        bit     was_busy = m_busy;
        int     was_idx  = m_idx;
        longint minv;
        if (!m_busy) begin
            m_to = 0;
            if (r != 0) begin
                // smallest effective key among requesters, then lowest index holding it
                minv = -1;
                for (int i = 0; i < 4; i++)
                    if (r[i] && (minv < 0 || eff(k[i], m_age[i]) < minv)) minv = eff(k[i], m_age[i]);
                for (int i = 3; i >= 0; i--)
                    if (r[i] && eff(k[i], m_age[i]) == minv) m_idx = i;
                m_busy = 1; m_last = m_idx; m_held = 0;
            end
        end else begin
            m_held++;
            if (d || !r[m_idx]) begin
                m_busy = 0; m_to = 0;
            end else if (m_held == HOLD_MAX) begin
                m_busy = 0; m_to = 1;
            end else begin
                m_to = 0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!r[i] || (was_busy && was_idx == i)) m_age[i] = 0;
            else if (m_age[i] < (1 << AGE_W) - 1) m_age[i]++;
        end
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".gnt"},     gnt,     m_busy ? (64'd1 << m_idx) : 64'd0);
        chk({tag, ".gnt_vld"}, gnt_vld, m_busy);
        chk({tag, ".gnt_idx"}, gnt_idx, m_last);
        chk({tag, ".timeout"}, timeout, m_to);
    endtask

    // Drive one cycle of inputs just after a falling edge, check after the next.
    task automatic cyc(input string tag, input logic [3:0] r,
                       input longint k0, input longint k1, input longint k2, input longint k3,
                       input bit d);
        longint k[4];
        k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
        req = r; key0 = KEY_W'(k0); key1 = KEY_W'(k1); key2 = KEY_W'(k2); key3 = KEY_W'(k3);
        done = d;
        model_step(r, k, d);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        logic [3:0] r;
        bit         d;
        rst_n = 1'b0; req = '0; done = 1'b0;
        key0 = '0; key1 = '0; key2 = '0; key3 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // single requester, done, bubble
        cyc("single", 4'b0100, 0, 0, 5, 0, 0);
        chk("single.exp_gnt", gnt, 4'b0100);
        cyc("single_d", 4'b0100, 0, 0, 5, 0, 1);
        chk("single.rel", gnt, 4'b0000);
        cyc("bubble", 4'b0000, 0, 0, 5, 0, 0);

        // min selection then next min after dropping the winner
        cyc("min", 4'b1111, 40, 10, 30, 20, 0);
        chk("min.exp_gnt", gnt, 4'b0010);
        cyc("min_d", 4'b1111, 40, 10, 30, 20, 1);
        cyc("min2", 4'b1101, 40, 10, 30, 20, 0);
        chk("min2.exp_gnt", gnt, 4'b1000);
        cyc("min2_d", 4'b1101, 40, 10, 30, 20, 1);
        cyc("idle", 4'b0000, 0, 0, 0, 0, 0);

        // ties and masking
        cyc("tie", 4'b1111, 7, 7, 3, 3, 0);
        chk("tie.exp_gnt", gnt, 4'b0100);
        cyc("tie_d", 4'b1111, 7, 7, 3, 3, 1);
        cyc("idle", 4'b0000, 0, 0, 0, 0, 0);
        cyc("mask", 4'b1011, 9, 9, 0, 9, 0);
        chk("mask.exp_gnt", gnt, 4'b0001);

        // timeout: hold with no done
        for (int i = 0; i < HOLD_MAX; i++) cyc("hold", 4'b1011, 9, 9, 0, 9, 0);
        chk("to.pulse", timeout, 1'b1);
        chk("to.gnt", gnt, 4'b0000);
        cyc("to_after", 4'b0000, 0, 0, 0, 0, 0);

        // done coincident with timeout condition: no pulse
        cyc("dt", 4'b0001, 1, 0, 0, 0, 0);
        for (int i = 0; i < HOLD_MAX - 1; i++) cyc("dt_hold", 4'b0001, 1, 0, 0, 0, 0);
        cyc("dt_done", 4'b0001, 1, 0, 0, 0, 1);
        chk("dt.no_pulse", timeout, 1'b0);

        // abort
        cyc("ab", 4'b0010, 0, 3, 0, 0, 0);
        cyc("ab_drop", 4'b0000, 0, 3, 0, 0, 0);
        chk("ab.gnt", gnt, 4'b0000);

        // async reset mid-grant
        cyc("rst_g", 4'b1000, 0, 0, 0, 2, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.gnt", gnt, 4'b0000);
        chk("rst.vld", gnt_vld, 1'b0);
        chk("rst.idx", gnt_idx, 2'd0);
        chk("rst.to", timeout, 1'b0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MIN_KEY_ARB_AGING_EN
        // requester 0 (key 100) waits behind requester 1 (key 98)
        for (int g = 0; g < 3; g++) begin
            cyc("age_g", 4'b0011, 100, 98, 0, 0, 0);
            cyc("age_d", 4'b0011, 100, 98, 0, 0, 1);
        end
        cyc("age_win", 4'b0011, 100, 98, 0, 0, 0);
        chk("age.exp_gnt", gnt, 4'b0001);
        cyc("age_win_d", 4'b0011, 100, 98, 0, 0, 1);
        cyc("idle", 4'b0000, 0, 0, 0, 0, 0);
        // saturation: long hold by requester 0 (tiny key), requester 3 ages
        for (int i = 0; i < 300; i++) begin
            d = (m_busy && m_held == HOLD_MAX - 1);
            cyc("age_sat", 4'b1001, 0, 0, 0, 1000, d);
        end
        cyc("idle", 4'b0000, 0, 0, 0, 0, 0);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            r = 4'($urandom_range(0, 15));
            if (m_busy && $urandom_range(0, 7) != 0) r[m_idx] = 1'b1;
            d = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0)
                cyc("rnd", r, $urandom, $urandom, $urandom, $urandom, d);
            else
                cyc("rnd", r, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7), d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
